// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two writeback sources, the arbiter and the regfile write port.
// The arbiter uses the slave modport; requesters and the regfile side use master.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;

    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              idle;

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready,
        input  wen, waddr, wdata, idle
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready,
        output wen, waddr, wdata, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile's single write port between pipeline writeback (req0) and
// long-latency writeback (req1); writes to x0 are acknowledged and discarded.
module regfile_wb_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    regfile_wb_arbiter_if.slave  bus
);
    localparam bit FIXED = (FIXED_PRIORITY != 0);

    logic              req0_nz;
    logic              req1_nz;
    logic              grant0;
    logic              grant1;
    logic              last_grant;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    // Grant selection among non-zero-destination requests
    always_comb begin
        req0_nz = 1'b0;
        req1_nz = 1'b0;
        grant0  = 1'b0;
        grant1  = 1'b0;
        req0_nz = bus.req0_valid && (bus.req0_rd != ADDR_W'(0));
        req1_nz = bus.req1_valid && (bus.req1_rd != ADDR_W'(0));
        if (req0_nz && req1_nz) begin
            if (FIXED || (last_grant == 1'b0)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else begin
            grant0 = req0_nz;
            grant1 = req1_nz;
        end
    end

    // x0 writes are always accepted; no back-pressure from the write port
    assign bus.req0_ready = resetn && bus.req0_valid && (!req0_nz || grant0);
    assign bus.req1_ready = resetn && bus.req1_valid && (!req1_nz || grant1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wen_q      <= 1'b0;
            waddr_q    <= ADDR_W'(0);
            wdata_q    <= DATA_W'(0);
            last_grant <= 1'b1;
        end else begin
            wen_q <= grant0 || grant1;
            if (grant1) begin
                waddr_q    <= bus.req1_rd;
                wdata_q    <= bus.req1_data;
                last_grant <= 1'b1;
            end else if (grant0) begin
                waddr_q    <= bus.req0_rd;
                wdata_q    <= bus.req0_data;
                last_grant <= 1'b0;
            end
        end
    end

    assign bus.wen   = wen_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.idle  = !resetn || (!bus.req0_valid && !bus.req1_valid && !wen_q);
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the register file's single write port between two writeback sources: the in-order pipeline writeback (requester 0) and the long-latency unit writeback, e.g. load/multiply (requester 1). Each source presents a valid/ready handshake carrying a destination address and data. The arbiter grants one non-zero-destination write per cycle and drives a registered wen/waddr/wdata triple into the regfile write port. Writes to x0 are accepted and discarded without consuming the port.

## Interface
- FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 1 always wins contention

- clk  in  1  system clock; all state updates on posedge
- resetn  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a write pending
- req0_ready  out  1  requester 0 write accepted this cycle
- req0_rd  in  addr_t  requester 0 destination register
- req0_data  in  word_t  requester 0 write data
- req1_valid  in  1  requester 1 has a write pending
- req1_ready  out  1  requester 1 write accepted this cycle
- req1_rd  in  addr_t  requester 1 destination register
- req1_data  in  word_t  requester 1 write data
- wen  out  1  regfile write enable (registered)
- waddr  out  addr_t  regfile write address (registered)
- wdata  out  word_t  regfile write data (registered)
- idle  out  1  no request valid and no write in the output register

## Operation
- Transfer on requester i occurs on a posedge where reqi_valid && reqi_ready.
- Requester inputs must stay stable while valid and not ready; valid must not drop before transfer.
- Zero destination (reqi_rd == 0): reqi_ready = reqi_valid, unconditionally; data discarded; no wen; arbitration state unchanged.
- Non-zero destination: at most one granted per cycle.
  - Only one valid: granted.
  - Both valid, FIXED_PRIORITY = 0: grant goes to the requester not granted last (last_grant register).
  - Both valid, FIXED_PRIORITY = 1: requester 1 granted.
- last_grant updates to the granted index on every non-zero grant, in both modes; reset value 1, so requester 0 wins the first contention.
- Simultaneous zero and non-zero requests: both ready in the same cycle; the non-zero one wins the write.
- Same rd from both requesters in the same cycle: serialized in grant order; the later grant's data is final in the regfile. No merging.
- ready is combinational from valid, rd and last_grant. It does not depend on the output register because the write port accepts every cycle, so no back-pressure exists.
- idle = !req0_valid && !req1_valid && !wen.

## Timing
- Reset (resetn low, asynchronous): wen=0, waddr=0, wdata=0, last_grant=1. req0_ready and req1_ready are forced 0 while resetn is low; idle=1.
- Latency: a non-zero grant at posedge N drives wen=1, waddr=rd and wdata=data during cycle N..N+1. The regfile commits at the negedge inside that cycle, so a regfile read in the second half of that cycle or later sees the new value.
- wen is high exactly one cycle per non-zero grant. Back-to-back grants give wen continuously high, with waddr/wdata updating each cycle.
- No grant at a posedge: wen=0 next cycle. waddr/wdata hold their previous values (don't-care).
- Reset asserted mid-operation: the pending output write is dropped (wen=0 immediately). Un-accepted requests are not lost; requesters must hold them, and the first cycle after release behaves as after power-up.
- Throughput: one regfile write per cycle. Under continuous contention with FIXED_PRIORITY=0, each requester gets exactly every other cycle.

## Test plan
- Reset: hold resetn=0 with both valids high → wen=0, both readys 0, idle=1. Release → the first contention grants req0.
- Single source: req0 writes rd=5, data=0xDEADBEEF at posedge N → wen=1, waddr=5, wdata=0xDEADBEEF during cycle N; regfile x5 reads 0xDEADBEEF afterward; wen=0 in cycle N+1.
- Contention, round-robin: both valid with rd=3/0x11 and rd=3/0x22 held → grants in the order req0 then req1. Final x3=0x22; wen high 2 consecutive cycles. With 6 cycles of continuous traffic, each requester is granted 3 times, alternating.
- FIXED_PRIORITY=1: continuous contention → req1 granted every cycle and req0 starved until req1_valid drops, then req0 granted next posedge.
- x0 handling: req0 rd=0 and req1 rd=7 valid together → both ready same cycle; single write to x7; x0 still reads 0. Repeated rd=0 requests alone → wen never asserts and last_grant is unchanged.
- Async reset mid-burst: assert resetn low between posedges while wen=1 → wen drops immediately without a clock edge; after release no spurious write occurs.
